// File: rtl/dbg_hart_ctrl.sv
// ---------------------------------------------------------------------------
// dbg_hart_ctrl
//
// Multi-hart debug controller placed between a debug module and NUM_HARTS
// rv32i cores. It tracks the halt/resume state of every hart, drives the
// per-core halt/resume request handshakes, and serialises abstract register
// accesses (CSR/GPR) to one halted hart at a time. Busy, not-halted and
// timeout conditions are reported through a sticky error code.
//
// Ports
//   clk, reset_n      clock, synchronous active-low reset
//   hartsel           hart addressed by halt/resume/abstract commands
//   haltreq/resumereq level requests to the selected hart
//   ar_req/ar_wr/ar_ad/ar_wdata   abstract command strobe and payload
//   ar_err_clr        clears the sticky error code
//   ar_busy/ar_done/ar_rdata/ar_err   abstract command status and result
//   hart_halted/hart_resumeack        per-hart status (resumeack is sticky)
//   core_haltreq/core_resumereq       per-core request handshakes
//   core_halted/core_running          per-core status from the cores
//   core_ar_en/core_ar_wr/core_ar_ad/core_ar_do   access to the target core
//   core_ar_di/core_ar_done           per-core read data and completion
//
// All outputs are flops loaded from the next-state decode, so a request
// sampled on one edge is visible on the core side right after that edge.
// ---------------------------------------------------------------------------
module dbg_hart_ctrl #(
    parameter int NUM_HARTS  = 4,
    parameter int HSEL_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    parameter int AR_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [HSEL_W-1:0]         hartsel,
    input  logic                      haltreq,
    input  logic                      resumereq,
    input  logic                      ar_req,
    input  logic                      ar_wr,
    input  logic [15:0]               ar_ad,
    input  logic [31:0]               ar_wdata,
    input  logic                      ar_err_clr,
    output logic                      ar_busy,
    output logic                      ar_done,
    output logic [31:0]               ar_rdata,
    output logic [2:0]                ar_err,
    output logic [NUM_HARTS-1:0]      hart_halted,
    output logic [NUM_HARTS-1:0]      hart_resumeack,
    output logic [NUM_HARTS-1:0]      core_haltreq,
    output logic [NUM_HARTS-1:0]      core_resumereq,
    input  logic [NUM_HARTS-1:0]      core_halted,
    input  logic [NUM_HARTS-1:0]      core_running,
    output logic [NUM_HARTS-1:0]      core_ar_en,
    output logic                      core_ar_wr,
    output logic [15:0]               core_ar_ad,
    output logic [31:0]               core_ar_do,
    input  logic [32*NUM_HARTS-1:0]   core_ar_di,
    input  logic [NUM_HARTS-1:0]      core_ar_done
);

    localparam int CNT_W = $clog2(AR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        H_RUN,
        H_HALTING,
        H_HALTED,
        H_RESUMING
    } hart_state_t;

    typedef enum logic {
        AR_IDLE,
        AR_WAIT
    } ar_state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BUSY     = 3'd1,
        ERR_TIMEOUT  = 3'd3,
        ERR_NOT_HALT = 3'd4
    } ar_err_t;

    // -----------------------------------------------------------------------
    // State and next-state signals
    // -----------------------------------------------------------------------
    hart_state_t            hart_q [NUM_HARTS];
    hart_state_t            hart_d [NUM_HARTS];
    ar_state_t              ar_state_q, ar_state_d;
    logic [NUM_HARTS-1:0]   tgt_q, tgt_d;          // one-hot latched target
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_HARTS-1:0]   hart_halted_d;
    logic [NUM_HARTS-1:0]   hart_resumeack_d;
    logic [NUM_HARTS-1:0]   core_haltreq_d;
    logic [NUM_HARTS-1:0]   core_resumereq_d;
    logic [NUM_HARTS-1:0]   core_ar_en_d;
    logic                   ar_busy_d;
    logic                   ar_done_d;
    logic [31:0]            ar_rdata_d;
    logic [2:0]             ar_err_d;
    logic                   core_ar_wr_d;
    logic [15:0]            core_ar_ad_d;
    logic [31:0]            core_ar_do_d;

    // -----------------------------------------------------------------------
    // Decodes shared by both FSMs
    // -----------------------------------------------------------------------
    logic [NUM_HARTS-1:0]   sel_oh;        // hartsel as one-hot; all-zero if out of range
    logic [NUM_HARTS-1:0]   halted_vec;    // harts currently in HALTED
    logic [NUM_HARTS-1:0]   resume_block;  // harts pinned in HALTED by the AR FSM
    logic [31:0]            rd_mux;
    logic                   sel_halted;
    logic                   ar_accept;
    logic                   ar_not_halted;
    logic                   wait_done;
    logic                   wait_timeout;
    logic                   busy_err;

    always_comb begin
        sel_oh     = '0;
        halted_vec = '0;
        rd_mux     = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            sel_oh[h]     = (hartsel == HSEL_W'(h));
            halted_vec[h] = (hart_q[h] == H_HALTED);
            if (tgt_q[h]) begin
                rd_mux = rd_mux | core_ar_di[32*h +: 32];
            end
        end
    end

    assign sel_halted    = |(sel_oh & halted_vec);
    assign ar_accept     = (ar_state_q == AR_IDLE) && ar_req && (ar_err == ERR_NONE) && sel_halted;
    assign ar_not_halted = (ar_state_q == AR_IDLE) && ar_req && (ar_err == ERR_NONE) && !sel_halted;
    assign wait_done     = (ar_state_q == AR_WAIT) && |(core_ar_done & tgt_q);
    // A done arriving on the last allowed cycle wins over the timeout.
    assign wait_timeout  = (ar_state_q == AR_WAIT) && !wait_done &&
                           (cnt_q == CNT_W'(AR_TIMEOUT - 1));
    assign busy_err      = (ar_state_q == AR_WAIT) && ar_req;

    // The hart being accessed, or about to be, must stay halted so the core
    // cannot run underneath an in-flight register access.
    assign resume_block  = ((ar_state_q == AR_WAIT) ? tgt_q : '0) |
                           (ar_accept ? sel_oh : '0);

    // -----------------------------------------------------------------------
    // Per-hart FSMs: next state and registered-output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path through this block leaves it unassigned and infers a latch.
        hart_resumeack_d = hart_resumeack;
        for (int h = 0; h < NUM_HARTS; h++) begin
            hart_d[h] = hart_q[h];
            unique case (hart_q[h])
                H_RUN: begin
                    // A self halt (ebreak) takes priority over a debugger halt.
                    if (core_halted[h]) begin
                        hart_d[h] = H_HALTED;
                    end else if (haltreq && sel_oh[h]) begin
                        hart_d[h] = H_HALTING;
                    end
                end
                H_HALTING: begin
                    if (core_halted[h]) begin
                        hart_d[h] = H_HALTED;
                    end
                end
                H_HALTED: begin
                    if (resumereq && sel_oh[h] && !haltreq && !resume_block[h]) begin
                        hart_d[h]           = H_RESUMING;
                        hart_resumeack_d[h] = 1'b0;
                    end
                end
                H_RESUMING: begin
                    if (core_running[h]) begin
                        hart_d[h]           = H_RUN;
                        hart_resumeack_d[h] = 1'b1;
                    end
                end
                default: hart_d[h] = H_RUN;
            endcase
        end

        hart_halted_d    = '0;
        core_haltreq_d   = '0;
        core_resumereq_d = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            hart_halted_d[h]    = (hart_d[h] == H_HALTED);
            core_haltreq_d[h]   = (hart_d[h] == H_HALTING);
            core_resumereq_d[h] = (hart_d[h] == H_RESUMING);
        end
    end

    // -----------------------------------------------------------------------
    // AR FSM: next state, counter, error and registered-output decode
    // -----------------------------------------------------------------------
    always_comb begin
        ar_state_d   = ar_state_q;
        tgt_d        = tgt_q;
        cnt_d        = '0;
        ar_rdata_d   = ar_rdata;
        core_ar_wr_d = core_ar_wr;
        core_ar_ad_d = core_ar_ad;
        core_ar_do_d = core_ar_do;
        ar_done_d    = ar_not_halted | wait_done | wait_timeout;

        unique case (ar_state_q)
            AR_IDLE: begin
                if (ar_accept) begin
                    ar_state_d   = AR_WAIT;
                    tgt_d        = sel_oh;
                    core_ar_wr_d = ar_wr;
                    core_ar_ad_d = ar_ad;
                    core_ar_do_d = ar_wdata;
                end
            end
            AR_WAIT: begin
                if (wait_done || wait_timeout) begin
                    ar_state_d = AR_IDLE;
                    if (wait_done && !core_ar_wr) begin
                        ar_rdata_d = rd_mux;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ar_state_d = AR_IDLE;
        endcase

        // Clear first, then any error raised this cycle overrides it.
        ar_err_d = ar_err;
        if (ar_err_clr)    ar_err_d = ERR_NONE;
        if (busy_err)      ar_err_d = ERR_BUSY;
        if (ar_not_halted) ar_err_d = ERR_NOT_HALT;
        if (wait_timeout)  ar_err_d = ERR_TIMEOUT;

        ar_busy_d    = (ar_state_d == AR_WAIT);
        core_ar_en_d = (ar_state_d == AR_WAIT) ? tgt_d : '0;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                hart_q[h] <= H_RUN;
            end
            ar_state_q     <= AR_IDLE;
            tgt_q          <= '0;
            cnt_q          <= '0;
            hart_halted    <= '0;
            hart_resumeack <= '0;
            core_haltreq   <= '0;
            core_resumereq <= '0;
            core_ar_en     <= '0;
            core_ar_wr     <= 1'b0;
            core_ar_ad     <= '0;
            core_ar_do     <= '0;
            ar_busy        <= 1'b0;
            ar_done        <= 1'b0;
            ar_rdata       <= '0;
            ar_err         <= ERR_NONE;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                hart_q[h] <= hart_d[h];
            end
            ar_state_q     <= ar_state_d;
            tgt_q          <= tgt_d;
            cnt_q          <= cnt_d;
            hart_halted    <= hart_halted_d;
            hart_resumeack <= hart_resumeack_d;
            core_haltreq   <= core_haltreq_d;
            core_resumereq <= core_resumereq_d;
            core_ar_en     <= core_ar_en_d;
            core_ar_wr     <= core_ar_wr_d;
            core_ar_ad     <= core_ar_ad_d;
            core_ar_do     <= core_ar_do_d;
            ar_busy        <= ar_busy_d;
            ar_done        <= ar_done_d;
            ar_rdata       <= ar_rdata_d;
            ar_err         <= ar_err_d;
        end
    end

endmodule

// File: tb/tb_dbg_hart_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dbg_hart_ctrl
//
// Directed bench for dbg_hart_ctrl (NUM_HARTS=4, AR_TIMEOUT=16). Abstract
// command results are checked through a scoreboard: each command that should
// complete pushes its expected rdata, error code and completion cycle, and
// an independent monitor pops and compares on every ar_done pulse. Hart
// handshakes and reset behaviour are checked directly after each edge.
// A tiny core model answers accesses after a programmable number of cycles.
// ---------------------------------------------------------------------------
module tb_dbg_hart_ctrl;

    localparam int NH = 4;
    localparam int HW = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [HW-1:0]   hartsel;
    logic            haltreq, resumereq;
    logic            ar_req, ar_wr, ar_err_clr;
    logic [15:0]     ar_ad;
    logic [31:0]     ar_wdata;
    logic            ar_busy, ar_done;
    logic [31:0]     ar_rdata;
    logic [2:0]      ar_err;
    logic [NH-1:0]   hart_halted, hart_resumeack, core_haltreq, core_resumereq;
    logic [NH-1:0]   core_halted, core_running, core_ar_en, core_ar_done;
    logic            core_ar_wr;
    logic [15:0]     core_ar_ad;
    logic [31:0]     core_ar_do;
    logic [32*NH-1:0] core_ar_di;
    logic [31:0]     di_word [NH];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    dbg_hart_ctrl #(.NUM_HARTS(NH), .HSEL_W(HW), .AR_TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hartsel        (hartsel),
        .haltreq        (haltreq),
        .resumereq      (resumereq),
        .ar_req         (ar_req),
        .ar_wr          (ar_wr),
        .ar_ad          (ar_ad),
        .ar_wdata       (ar_wdata),
        .ar_err_clr     (ar_err_clr),
        .ar_busy        (ar_busy),
        .ar_done        (ar_done),
        .ar_rdata       (ar_rdata),
        .ar_err         (ar_err),
        .hart_halted    (hart_halted),
        .hart_resumeack (hart_resumeack),
        .core_haltreq   (core_haltreq),
        .core_resumereq (core_resumereq),
        .core_halted    (core_halted),
        .core_running   (core_running),
        .core_ar_en     (core_ar_en),
        .core_ar_wr     (core_ar_wr),
        .core_ar_ad     (core_ar_ad),
        .core_ar_do     (core_ar_do),
        .core_ar_di     (core_ar_di),
        .core_ar_done   (core_ar_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done rises done_delay cycles after core_ar_en goes high
    // (0 = combinational from en, 8'hFF = effectively never).
    logic [7:0] en_cnt = 8'd0;
    logic [7:0] done_delay = 8'd0;
    always @(posedge clk) begin
        if (core_ar_en == '0) en_cnt <= 8'd0;
        else                  en_cnt <= en_cnt + 8'd1;
    end
    assign core_ar_done = (en_cnt == done_delay) ? core_ar_en : '0;
    assign core_ar_di   = {di_word[3], di_word[2], di_word[1], di_word[0]};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input logic [31:0] d, input logic [2:0] e, input int lat);
        sb.push_back('{rdata: d, err: e, cyc: cyc + lat});
    endtask

    // Monitor: every ar_done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (ar_done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: ar_done=1 with no command pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_rdata", ar_rdata, e.rdata);
                check("done_err", ar_err, e.err);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        hartsel    = '0;
        haltreq    = 1'b0;
        resumereq  = 1'b0;
        ar_req     = 1'b0;
        ar_wr      = 1'b0;
        ar_ad      = '0;
        ar_wdata   = '0;
        ar_err_clr = 1'b0;
        core_halted  = '0;
        core_running = 4'b1111;
        for (int h = 0; h < NH; h++) di_word[h] = 32'h0;

        repeat (3) step();
        check("reset_outputs",
              {ar_busy, ar_done, ar_err, ar_rdata, hart_halted, hart_resumeack,
               core_haltreq, core_resumereq, core_ar_en, core_ar_wr, core_ar_ad, core_ar_do}, '0);
        reset_n = 1'b1;
        step();

        // Debugger halt of hart 2; the core reports halted three cycles later.
        hartsel = 2'd2;
        haltreq = 1'b1;
        step();
        check("halt_req_issued", core_haltreq, 4'b0100);
        check("halt_not_yet", hart_halted, 4'b0000);
        haltreq = 1'b0;
        step();
        step();
        check("halt_req_held", core_haltreq, 4'b0100);
        core_halted[2]  = 1'b1;
        core_running[2] = 1'b0;
        step();
        check("halted2", hart_halted, 4'b0100);
        check("haltreq_dropped", core_haltreq, 4'b0000);

        // Resume hart 2; the core reports running two cycles later.
        resumereq = 1'b1;
        step();
        check("resume_issued", core_resumereq, 4'b0100);
        check("resumeack_cleared", hart_resumeack, 4'b0000);
        resumereq      = 1'b0;
        core_halted[2] = 1'b0;
        step();
        check("resume_held", core_resumereq, 4'b0100);
        core_running[2] = 1'b1;
        step();
        check("resume_done", core_resumereq, 4'b0000);
        check("resumeack2", hart_resumeack, 4'b0100);
        check("halted2_clear", hart_halted, 4'b0000);

        // Self halt of hart 1, then haltreq+resumereq together must not resume.
        core_halted[1]  = 1'b1;
        core_running[1] = 1'b0;
        step();
        check("self_halt1", hart_halted, 4'b0010);
        hartsel   = 2'd1;
        haltreq   = 1'b1;
        resumereq = 1'b1;
        step();
        check("resume_ignored", core_resumereq, 4'b0000);
        check("still_halted1", hart_halted, 4'b0010);
        haltreq   = 1'b0;
        resumereq = 1'b0;
        core_halted[3]  = 1'b1;
        core_running[3] = 1'b0;
        step();
        check("self_halt3", hart_halted, 4'b1010);

        // Read from halted hart 1, core answers combinationally.
        di_word[1] = 32'hDEADBEEF;
        done_delay = 8'd0;
        hartsel    = 2'd1;
        ar_wr      = 1'b0;
        ar_ad      = 16'h1005;
        ar_req     = 1'b1;
        expect_done(32'hDEADBEEF, 3'd0, 2);
        step();
        ar_req = 1'b0;
        check("rd_en", core_ar_en, 4'b0010);
        check("rd_busy", ar_busy, 1'b1);
        check("rd_ad", core_ar_ad, 16'h1005);
        step();
        step();
        check("rd_en_drop", core_ar_en, 4'b0000);

        // Write to hart 1: payload latched, ar_rdata left alone.
        ar_wr    = 1'b1;
        ar_ad    = 16'h07B0;
        ar_wdata = 32'h12345678;
        ar_req   = 1'b1;
        expect_done(32'hDEADBEEF, 3'd0, 2);
        step();
        ar_req = 1'b0;
        check("wr_do", core_ar_do, 32'h12345678);
        check("wr_flag", core_ar_wr, 1'b1);
        step();
        step();

        // Access to running hart 0 -> not-halted error, no core access.
        hartsel = 2'd0;
        ar_wr   = 1'b0;
        ar_req  = 1'b1;
        expect_done(32'hDEADBEEF, 3'd4, 1);
        step();
        ar_req = 1'b0;
        check("nh_no_en", core_ar_en, 4'b0000);
        step();
        check("nh_err", ar_err, 3'd4);
        // With the error pending, a valid request is ignored.
        hartsel = 2'd1;
        ar_req  = 1'b1;
        step();
        ar_req = 1'b0;
        check("ignored_no_en", core_ar_en, 4'b0000);
        check("ignored_not_busy", ar_busy, 1'b0);
        step();
        ar_err_clr = 1'b1;
        step();
        ar_err_clr = 1'b0;
        check("err_cleared", ar_err, 3'd0);

        // Hart 3 never answers -> timeout 17 cycles after the request.
        done_delay = 8'hFF;
        hartsel    = 2'd3;
        ar_req     = 1'b1;
        expect_done(32'hDEADBEEF, 3'd3, 17);
        step();
        ar_req = 1'b0;
        check("to_en", core_ar_en, 4'b1000);
        repeat (15) step();
        check("to_en_held", core_ar_en, 4'b1000);
        step();
        step();
        check("to_en_low", core_ar_en, 4'b0000);
        check("to_err", ar_err, 3'd3);
        ar_err_clr = 1'b1;
        step();
        ar_err_clr = 1'b0;

        // Second request during WAIT -> busy error; first access still completes.
        di_word[1] = 32'hCAFEF00D;
        done_delay = 8'd3;
        hartsel    = 2'd1;
        ar_req     = 1'b1;
        expect_done(32'hCAFEF00D, 3'd1, 5);
        step();
        hartsel = 2'd0;
        step();
        ar_req = 1'b0;
        check("busy_err", ar_err, 3'd1);
        check("busy_en_kept", core_ar_en, 4'b0010);
        repeat (4) step();
        check("busy_rdata", ar_rdata, 32'hCAFEF00D);

        // Reset during WAIT returns everything to zero on the next edge.
        ar_err_clr = 1'b1;
        step();
        ar_err_clr = 1'b0;
        done_delay = 8'hFF;
        hartsel    = 2'd1;
        ar_req     = 1'b1;
        step();
        ar_req = 1'b0;
        check("mid_en", core_ar_en, 4'b0010);
        step();
        core_halted = '0;
        reset_n     = 1'b0;
        step();
        check("midwait_reset",
              {ar_busy, ar_done, ar_err, ar_rdata, hart_halted, hart_resumeack,
               core_haltreq, core_resumereq, core_ar_en, core_ar_wr, core_ar_ad, core_ar_do}, '0);
        reset_n = 1'b1;
        step();
        check("post_reset_run", hart_halted, 4'b0000);

        repeat (3) step();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbg_hart_ctrl.md
Name: dbg_hart_ctrl

Overview:
Parametrised multi-hart debug controller that sits between the debug module and NUM_HARTS rv32i cores.
- Tracks halt/resume state per hart and drives request handshakes to each core.
- Serialises abstract register accesses (CSR/GPR) to the selected hart.
- Detects busy, not-halted and timeout errors, and reports them through a sticky error code.

Parameters:
NUM_HARTS, 4, number of cores served (1..16)
HSEL_W, max(1,$clog2(NUM_HARTS)), hart-select width
AR_TIMEOUT, 16, max cycles to wait for core_ar_done (≥2)

Ports:
clk  in  1  clock
reset_n  in  1  reset
hartsel  in  HSEL_W  selected hart for halt/resume/abstract commands
haltreq  in  1  level halt request to selected hart
resumereq  in  1  level resume request to selected hart
ar_req  in  1  abstract command strobe
ar_wr  in  1  1=write, 0=read
ar_ad  in  16  register address
ar_wdata  in  32  write data
ar_err_clr  in  1  clears ar_err
ar_busy  out  1  abstract access in flight
ar_done  out  1  one-cycle completion pulse
ar_rdata  out  32  read result
ar_err  out  3  sticky: 0 none, 1 busy, 3 timeout, 4 hart not halted
hart_halted  out  NUM_HARTS  per-hart HALTED state
hart_resumeack  out  NUM_HARTS  sticky per-hart resume ack
core_haltreq  out  NUM_HARTS  per-core halt request
core_resumereq  out  NUM_HARTS  per-core resume request
core_halted  in  NUM_HARTS  core reports halted
core_running  in  NUM_HARTS  core reports running
core_ar_en  out  NUM_HARTS  per-core access enable
core_ar_wr  out  1  latched ar_wr
core_ar_ad  out  16  latched ar_ad
core_ar_do  out  32  latched ar_wdata
core_ar_di  in  32*NUM_HARTS  per-core read data, hart h at [32h+31:32h]
core_ar_done  in  NUM_HARTS  per-core access done (may be combinational from core_ar_en)

Behaviour:
Reset and clocking:
- One clock, clk. Reset is synchronous and active-low (reset_n).
- Every output resets to 0. Hart FSMs reset to RUN. AR FSM resets to IDLE with the timeout counter cleared.
- All outputs are registered (Moore decodes).
- A request sampled at edge N appears on core_* at cycle N+1.

Per-hart FSM (h = hartsel for requests):
- RUN: haltreq & sel → HALTING. core_halted[h] (self halt, e.g. ebreak) → HALTED; this takes priority over haltreq.
- HALTING: core_haltreq[h]=1 held until core_halted[h]=1 → HALTED.
- HALTED: hart_halted[h]=1. resumereq & sel & !haltreq → RESUMING, clearing hart_resumeack[h]. haltreq & resumereq together: resume is ignored.
- RESUMING: core_resumereq[h]=1 held until core_running[h]=1 → RUN, setting hart_resumeack[h]=1.
- Unselected harts ignore haltreq and resumereq.

AR FSM:
- IDLE: ar_req with ar_err≠0 → ignored, no ar_done.
- IDLE: ar_req with ar_err=0 and target hart not HALTED → ar_err=4, ar_done pulse next cycle, no core access.
- IDLE: otherwise latch hartsel/ar_wr/ar_ad/ar_wdata → WAIT.
- WAIT: ar_busy=1 and core_ar_en[tgt]=1 (one-hot, held).
  - On core_ar_done[tgt]: capture core_ar_di[tgt] into ar_rdata (reads only; writes leave ar_rdata unchanged), pulse ar_done, drop en, return to IDLE.
  - Counter increments every WAIT cycle. If it reaches AR_TIMEOUT without done → ar_err=3, ar_done pulse, en dropped, IDLE. Done in the same cycle the counter reaches AR_TIMEOUT counts as success.
- ar_req during WAIT → ar_err=1 (sticky). The in-flight access continues unaffected.
- Latency: ar_req at edge N → en high at N+1. With a combinational core done, ar_done=1 at N+2.
- hartsel changes during WAIT do not affect the latched target.
- ar_err_clr clears ar_err. If an error is set in the same cycle, the new error wins.
- The target hart FSM cannot leave HALTED while the AR FSM is in WAIT on that hart; its resumereq is held off until IDLE.

Reset mid-operation:
- reset_n low in any state → all FSMs, outputs and sticky bits return to reset values on the next edge.

Test Plan:
- hartsel=2, haltreq=1, core_halted[2] rises 3 cycles after core_haltreq[2] → hart_halted=4'b0100, core_haltreq[2] drops the cycle after halted; harts 0,1,3 untouched.
- Hart 2 halted, resumereq=1, core_running[2] after 2 cycles → core_resumereq[2] pulse train ends, hart_resumeack[2]=1, hart_halted[2]=0.
- Hart 1 halted, read ar_ad=16'h1005, core returns done combinationally with 32'hDEADBEEF → ar_done exactly 2 cycles after ar_req, ar_rdata=32'hDEADBEEF, ar_err=0.
- Access to a running hart 0 → ar_err=4, ar_done pulse, core_ar_en stays 0. A following ar_req is ignored until ar_err_clr.
- Halted hart 3, core never asserts done, AR_TIMEOUT=16 → ar_err=3, ar_done 17 cycles after ar_req, en low afterwards.
- Second ar_req during WAIT → ar_err=1 while the first access still completes with correct ar_rdata. Then reset_n=0 for 1 cycle mid-WAIT → all outputs 0 next cycle.
